// File: rtl/rs_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rs_div_pkg
// Description : Shared types and the CDB wakeup helper for the divide RS.
// Revision    : 1.0
// ============================================================================
package rs_div_pkg;

  localparam int ROB_TAG_W = 4;
  localparam int XLEN      = 32;

  typedef struct packed {
    logic [ROB_TAG_W-1:0] dest_ROB_entry;
    logic [XLEN-1:0]      result;
  } CDB_packet_t;

  typedef struct packed {
    logic                 valid;
    logic [ROB_TAG_W-1:0] rob_entry;
    logic [3:0]           ALUop;
    logic [XLEN-1:0]      vj;
    logic [XLEN-1:0]      vk;
    logic [ROB_TAG_W-1:0] qj;
    logic [ROB_TAG_W-1:0] qk;
    logic                 qj_pend;
    logic                 qk_pend;
  } rs_div_entry_t;

  typedef struct packed {
    logic [ROB_TAG_W-1:0] rob_entry;
    logic [3:0]           ALUop;
    logic [XLEN-1:0]      vj;
    logic [XLEN-1:0]      vk;
    logic [ROB_TAG_W-1:0] qj;
    logic [ROB_TAG_W-1:0] qk;
    logic                 qj_pend;
    logic                 qk_pend;
  } rs_dispatch_t;

  // Pending bit disambiguates tags, so every tag value is a legal match.
  function automatic rs_div_entry_t rs_div_wake(input rs_div_entry_t e,
                                                input logic          cdb_valid,
                                                input CDB_packet_t   cdb);
    rs_div_entry_t r;
    r = e;
    if (e.valid && cdb_valid) begin
      if (e.qj_pend && (e.qj == cdb.dest_ROB_entry)) begin
        r.vj      = cdb.result;
        r.qj_pend = 1'b0;
      end
      if (e.qk_pend && (e.qk == cdb.dest_ROB_entry)) begin
        r.vk      = cdb.result;
        r.qk_pend = 1'b0;
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rs_div_if.sv
`default_nettype none
// ============================================================================
// Module      : rs_div_if
// Description : Dispatch, CDB snoop and divider issue bundle for the divide RS.
// Revision    : 1.0
// ============================================================================
interface rs_div_if #(
  parameter int TAG_W = rs_div_pkg::ROB_TAG_W,
  parameter int DEPTH = 4
);
  import rs_div_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);

  logic             dispatch_valid;
  logic             dispatch_ready;
  logic [TAG_W-1:0] dispatch_rob_entry;
  logic [3:0]       dispatch_ALUop;
  logic [31:0]      dispatch_vj;
  logic [31:0]      dispatch_vk;
  logic [TAG_W-1:0] dispatch_qj;
  logic [TAG_W-1:0] dispatch_qk;
  logic             dispatch_qj_pend;
  logic             dispatch_qk_pend;
  logic             cdb_valid;
  CDB_packet_t      cdb;
  logic             fu_ready;
  logic             issue_valid;
  logic [TAG_W-1:0] issue_rob_entry;
  logic [3:0]       issue_ALUop;
  logic [31:0]      issue_dividend;
  logic [31:0]      issue_divisor;
  logic [CW-1:0]    count;

  modport master (
    output dispatch_valid, dispatch_rob_entry, dispatch_ALUop, dispatch_vj,
           dispatch_vk, dispatch_qj, dispatch_qk, dispatch_qj_pend,
           dispatch_qk_pend, cdb_valid, cdb, fu_ready,
    input  dispatch_ready, issue_valid, issue_rob_entry, issue_ALUop,
           issue_dividend, issue_divisor, count
  );

  modport slave (
    input  dispatch_valid, dispatch_rob_entry, dispatch_ALUop, dispatch_vj,
           dispatch_vk, dispatch_qj, dispatch_qk, dispatch_qj_pend,
           dispatch_qk_pend, cdb_valid, cdb, fu_ready,
    output dispatch_ready, issue_valid, issue_rob_entry, issue_ALUop,
           issue_dividend, issue_divisor, count
  );

endinterface
`default_nettype wire

// File: rtl/rs_div_slot.sv
`default_nettype none
// ============================================================================
// Module      : rs_div_slot
// Description : Per-entry CDB capture; ready reflects registered state only.
// Revision    : 1.0
// ============================================================================
module rs_div_slot
  import rs_div_pkg::*;
(
  input  rs_div_entry_t i_entry,
  input  logic          i_cdb_valid,
  input  CDB_packet_t   i_cdb,
  output rs_div_entry_t o_next,
  output logic          o_ready
);

  assign o_next  = rs_div_wake(i_entry, i_cdb_valid, i_cdb);
  assign o_ready = i_entry.valid & ~i_entry.qj_pend & ~i_entry.qk_pend;

endmodule
`default_nettype wire

// File: rtl/rs_div.sv
`default_nettype none
// ============================================================================
// Module      : rs_div
// Description : Collapsing-queue reservation station feeding the divide unit.
// Revision    : 1.0
// ============================================================================
module rs_div
  import rs_div_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = ROB_TAG_W
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   flush,
  rs_div_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  rs_div_entry_t    entries_q [DEPTH];
  rs_div_entry_t    entries_d [DEPTH];
  rs_div_entry_t    woken     [DEPTH+1];
  logic [DEPTH-1:0] slot_ready;
  logic [CW-1:0]    count_q, count_d, count_after;
  logic [IW-1:0]    sel;
  logic             any_ready, issue_fire, accept;
  rs_dispatch_t     disp;
  rs_div_entry_t    disp_entry;

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    rs_div_slot u_slot (
      .i_entry    (entries_q[i]),
      .i_cdb_valid(bus.cdb_valid),
      .i_cdb      (bus.cdb),
      .o_next     (woken[i]),
      .o_ready    (slot_ready[i])
    );
  end
  assign woken[DEPTH] = '0;

  always_comb begin
    any_ready = 1'b0;
    sel       = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (slot_ready[i]) begin
        any_ready = 1'b1;
        sel       = IW'(i);
      end
    end
  end

  // Divider captures on any valid_in, so never raise it while it is busy.
  assign issue_fire         = bus.fu_ready & any_ready;
  assign bus.dispatch_ready = (count_q < CW'(DEPTH));
  assign accept             = bus.dispatch_valid & bus.dispatch_ready;

  assign disp = '{rob_entry: bus.dispatch_rob_entry, ALUop: bus.dispatch_ALUop,
                  vj: bus.dispatch_vj, vk: bus.dispatch_vk,
                  qj: bus.dispatch_qj, qk: bus.dispatch_qk,
                  qj_pend: bus.dispatch_qj_pend, qk_pend: bus.dispatch_qk_pend};

  assign disp_entry = rs_div_wake('{valid: 1'b1, rob_entry: disp.rob_entry,
                                    ALUop: disp.ALUop, vj: disp.vj, vk: disp.vk,
                                    qj: disp.qj, qk: disp.qk,
                                    qj_pend: disp.qj_pend, qk_pend: disp.qk_pend},
                                  bus.cdb_valid, bus.cdb);

  always_comb begin
    count_after = count_q - CW'(issue_fire);
    for (int i = 0; i < DEPTH; i++) begin
      if (issue_fire && (i >= int'(sel))) entries_d[i] = woken[i+1];
      else                                entries_d[i] = woken[i];
      if (accept && (count_after == CW'(i))) entries_d[i] = disp_entry;
    end
    count_d = count_after + CW'(accept);
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) entries_d[i] = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      count_q <= '0;
    end else begin
      entries_q <= entries_d;
      count_q   <= count_d;
    end
  end

  assign bus.issue_valid     = issue_fire;
  assign bus.issue_rob_entry = issue_fire ? entries_q[sel].rob_entry : '0;
  assign bus.issue_ALUop     = issue_fire ? entries_q[sel].ALUop     : '0;
  assign bus.issue_dividend  = issue_fire ? entries_q[sel].vj        : '0;
  assign bus.issue_divisor   = issue_fire ? entries_q[sel].vk        : '0;
  assign bus.count           = count_q;

endmodule
`default_nettype wire
